pmp_seq_checker: RTL and testbench
==================================

Name: pmp_seq_checker

Overview:
- Area-optimised PMP checker that time-multiplexes one single-entry address matcher (TOR/NA4/NAPOT) across all configured PMP entries.
- Accepts one physical-address check per request. Scans entries in ascending index order, one entry per cycle, stopping at the first match (lowest-index priority).
- Returns allow/deny plus match info over a valid/ready response channel.
- Used by slow-path requesters such as the PTW and debug/system bus, where multi-cycle latency is acceptable.

Parameters:
- PLEN, 56, physical address width.
- PMP_LEN, 54, width of each pmpaddr register.
- NR_ENTRIES, 16, number of PMP entries; legal range 1..64.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  check request valid.
- req_ready_o  out  1  checker can accept a request.
- addr_i  in  PLEN  physical address to check.
- access_i  in  3  requested access, bit0 R, bit1 W, bit2 X.
- priv_m_i  in  1  request is machine mode.
- conf_addr_i  in  NR_ENTRIES*PMP_LEN  pmpaddr registers, entry k at [k*PMP_LEN +: PMP_LEN].
- conf_i  in  NR_ENTRIES*8  pmpcfg bytes: bit0 R, bit1 W, bit2 X, bits4:3 A (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), bit7 L.
- flush_i  in  1  abort any in-flight check.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  requester accepts result.
- allow_o  out  1  access permitted.
- matched_o  out  1  an entry matched.
- match_idx_o  out  $clog2(NR_ENTRIES) (min 1)  index of the matching entry, 0 if none.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values: state IDLE; req_ready_o=1; rsp_valid_o=0; allow_o=0; matched_o=0; match_idx_o=0; internal index counter 0.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: latch addr_i, access_i and priv_m_i; clear index to 0; go to SCAN.
- SCAN:
  - req_ready_o=0.
  - Matcher inputs: conf_addr[idx]; prev = 0 when idx==0, else conf_addr[idx-1]; mode = conf[idx].A.
  - TOR match: (prev<<2) <= addr < (conf_addr<<2).
  - NA4: 4-byte region.
  - NAPOT: region size 2^(trailing_ones(conf_addr)+3).
  - OFF never matches but still costs one cycle.
- On match at idx:
  - matched_o=1, match_idx_o=idx.
  - allow_o=1 if priv_m and L==0.
  - Otherwise allow_o = ((access & ~{X,W,R}) == 0), i.e. every requested bit is granted; access==0 is allowed.
  - Go to RESP.
- No match at idx==NR_ENTRIES-1: matched_o=0, match_idx_o=0, allow_o=priv_m; go to RESP. Otherwise idx increments.
- Latency: a match at entry k gives rsp_valid_o=1 in cycle T+k+2, where T is the accept cycle. A full miss gives rsp_valid_o in cycle T+NR_ENTRIES+1.
- RESP:
  - rsp_valid_o=1 and allow_o/matched_o/match_idx_o held stable until rsp_ready_i.
  - On the handshake cycle, go to IDLE. No new request is accepted in that same cycle; req_ready_o rises in the following cycle.
- Result outputs keep their last values in IDLE and SCAN; only rsp_valid_o qualifies them.
- Configuration must be stable from accept to response. A config change mid-scan is not detected; software fences with flush_i.
- flush_i:
  - In SCAN or RESP: go to IDLE next cycle, rsp_valid_o=0, no response produced.
  - In IDLE: a simultaneous req_valid_i is dropped.
  - flush_i has priority over all other events.
- Reset mid-scan: immediate return to reset values; the pending request is lost.
- Arithmetic:
  - Address compares are unsigned at PLEN bits, with pmpaddr zero-extended then shifted left by 2.
  - The NAPOT trailing-ones count saturates at PMP_LEN (all ones means the whole space).
  - The index counter never wraps past NR_ENTRIES-1.

Test Plan:
- Reset: assert rst_i mid-SCAN -> next cycle req_ready_o=1, rsp_valid_o=0, allow_o=0.
- TOR hit:
  - Config: entry0 pmpaddr=0x400 TOR R only.
  - Request: addr=0x800, R, user mode -> rsp_valid_o at T+2, matched_o=1, match_idx_o=0, allow_o=1.
  - Same request with W -> allow_o=0.
- NAPOT priority:
  - Config: entries 0..2 OFF; entry3 NAPOT pmpaddr=0x2003 (32-byte region at 0x8000) RWX; entry5 NAPOT covering same address, no perms.
  - Request: addr=0x8010, X -> rsp at T+5, match_idx_o=3, allow_o=1.
- Full miss, NR_ENTRIES=16, all OFF:
  - User-mode request -> rsp at T+17, matched_o=0, allow_o=0.
  - Machine-mode request -> allow_o=1.
- Lock:
  - Config: entry0 NA4 at 0x1000 (pmpaddr 0x400), L=1, R only.
  - Request: M-mode W to 0x1000 -> allow_o=0.
  - Same entry with L=0 -> allow_o=1.
- Backpressure and flush:
  - Hold rsp_ready_i=0 for 5 cycles -> outputs stable, req_ready_o=0.
  - Assert flush_i during RESP -> rsp_valid_o=0 next cycle, then accept a new request normally.

Source files
------------

// File: rtl/pmp_seq_checker.sv
// Sequential PMP checker: one TOR/NA4/NAPOT matcher is stepped across the PMP
// entries in ascending index order, and the first matching entry decides the result.
module pmp_seq_checker #(
  parameter  int unsigned PLEN       = 56,
  parameter  int unsigned PMP_LEN    = 54,
  parameter  int unsigned NR_ENTRIES = 16,
  localparam int unsigned IDX_W      = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [PLEN-1:0]              addr_i,
  input  logic [2:0]                   access_i,
  input  logic                         priv_m_i,
  input  logic [NR_ENTRIES*PMP_LEN-1:0] conf_addr_i,
  input  logic [NR_ENTRIES*8-1:0]      conf_i,
  input  logic                         flush_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic                         allow_o,
  output logic                         matched_o,
  output logic [IDX_W-1:0]             match_idx_o
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

  localparam int unsigned      TZ_W     = $clog2(PMP_LEN + 4);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);
  localparam logic [PLEN-1:0]  NA4_MASK = {PLEN{1'b1}} << 2;

  state_e           r_state, w_next;
  logic [PLEN-1:0]  r_addr;
  logic [2:0]       r_access;
  logic             r_priv;
  logic [IDX_W-1:0] r_idx;
  logic             r_allow, r_matched;
  logic [IDX_W-1:0] r_match_idx;

  logic [PMP_LEN-1:0] w_pmpaddr [NR_ENTRIES];
  logic [7:0]         w_pmpcfg  [NR_ENTRIES];

  for (genvar k = 0; k < NR_ENTRIES; k++) begin : g_unpack
    assign w_pmpaddr[k] = conf_addr_i[k*PMP_LEN +: PMP_LEN];
    assign w_pmpcfg[k]  = conf_i[k*8 +: 8];
  end

  logic [IDX_W-1:0]   w_prev_idx;
  logic [PMP_LEN-1:0] w_cur, w_prev;
  logic [7:0]         w_cfg;
  logic [PLEN-1:0]    w_cur_base, w_prev_base, w_napot_mask;
  logic [TZ_W-1:0]    w_tz, w_sh;
  logic               w_run, w_match, w_last, w_perm_ok, w_hit_allow;
  logic               w_unused;

  assign w_prev_idx  = r_idx - 1'b1;
  assign w_cur       = w_pmpaddr[r_idx];
  assign w_prev      = (r_idx == '0) ? '0 : w_pmpaddr[w_prev_idx];
  assign w_cfg       = w_pmpcfg[r_idx];
  assign w_cur_base  = PLEN'({w_cur, 2'b00});
  assign w_prev_base = PLEN'({w_prev, 2'b00});
  assign w_unused    = ^w_cfg[6:5];

  // Trailing-ones count saturates at PMP_LEN; a shift of PMP_LEN+3 clears the whole mask.
  always_comb begin
    w_tz  = '0;
    w_run = 1'b1;
    for (int i = 0; i < PMP_LEN; i++) begin
      if (w_run && w_cur[i]) w_tz = w_tz + 1'b1;
      else                   w_run = 1'b0;
    end
  end

  assign w_sh         = w_tz + TZ_W'(3);
  assign w_napot_mask = {PLEN{1'b1}} << w_sh;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_match = 1'b0;
    case (w_cfg[4:3])
      2'd1:    w_match = (r_addr >= w_prev_base) && (r_addr < w_cur_base);
      2'd2:    w_match = (r_addr & NA4_MASK) == (w_cur_base & NA4_MASK);
      2'd3:    w_match = (r_addr & w_napot_mask) == (w_cur_base & w_napot_mask);
      default: w_match = 1'b0;
    endcase
  end

  assign w_last      = (r_idx == LAST_IDX);
  assign w_perm_ok   = ((r_access & ~w_cfg[2:0]) == 3'b000);
  assign w_hit_allow = (r_priv && !w_cfg[7]) || w_perm_ok;

  // NOTE: sequential state uses non-blocking assignments and the async reset only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush_i) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (req_valid_i)        w_next = SCAN;
        SCAN:    if (w_match || w_last)  w_next = RESP;
        RESP:    if (rsp_ready_i)        w_next = IDLE;
        default:                         w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o = (r_state == IDLE);
    rsp_valid_o = (r_state == RESP);
    allow_o     = r_allow;
    matched_o   = r_matched;
    match_idx_o = r_match_idx;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr      <= '0;
      r_access    <= '0;
      r_priv      <= 1'b0;
      r_idx       <= '0;
      r_allow     <= 1'b0;
      r_matched   <= 1'b0;
      r_match_idx <= '0;
    end else if (!flush_i) begin
      if (r_state == IDLE && req_valid_i) begin
        r_addr   <= addr_i;
        r_access <= access_i;
        r_priv   <= priv_m_i;
        r_idx    <= '0;
      end else if (r_state == SCAN) begin
        if (w_match) begin
          r_matched   <= 1'b1;
          r_match_idx <= r_idx;
          r_allow     <= w_hit_allow;
        end else if (w_last) begin
          r_matched   <= 1'b0;
          r_match_idx <= '0;
          r_allow     <= r_priv;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pmp_seq_checker.sv
// Bench for pmp_seq_checker: directed table vectors, multi-cycle corner sequences,
// and random configurations compared against a region-based reference model.
module tb_pmp_seq_checker;

  localparam int PLEN    = 56;
  localparam int PMP_LEN = 54;
  localparam int NR      = 16;
  localparam int IDX_W   = 4;

  logic                    clk_i, rst_i;
  logic                    req_valid_i, req_ready_o;
  logic [PLEN-1:0]         addr_i;
  logic [2:0]              access_i;
  logic                    priv_m_i;
  logic [NR*PMP_LEN-1:0]   conf_addr_i;
  logic [NR*8-1:0]         conf_i;
  logic                    flush_i;
  logic                    rsp_valid_o, rsp_ready_i;
  logic                    allow_o, matched_o;
  logic [IDX_W-1:0]        match_idx_o;

  logic [PMP_LEN-1:0] cfg_addr [NR];
  logic [7:0]         cfg      [NR];

  int checks = 0;
  int errors = 0;

  pmp_seq_checker #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .addr_i(addr_i), .access_i(access_i), .priv_m_i(priv_m_i),
    .conf_addr_i(conf_addr_i), .conf_i(conf_i), .flush_i(flush_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .allow_o(allow_o), .matched_o(matched_o), .match_idx_o(match_idx_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      conf_addr_i[k*PMP_LEN +: PMP_LEN] = cfg_addr[k];
      conf_i[k*8 +: 8]                  = cfg[k];
    end
  end

  typedef struct {
    logic [PLEN-1:0] addr;
    logic [2:0]      acc;
    logic            pm;
    logic            exp_m;
    int              exp_idx;
    logic            exp_allow;
    int              exp_lat;
  } vec_t;

  vec_t tor_vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_cfg();
    for (int k = 0; k < NR; k++) begin
      cfg_addr[k] = '0;
      cfg[k]      = 8'h00;
    end
  endtask

  // Drives one request from IDLE; lat ends as the cycle offset from the accept cycle.
  task automatic issue(input logic [PLEN-1:0] a, input logic [2:0] acc, input logic pm,
                       output int lat);
    addr_i      = a;
    access_i    = acc;
    priv_m_i    = pm;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    lat = 1;
    while (!rsp_valid_o && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_rsp(input int delay);
    repeat (delay) tick();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  task automatic do_check(input string name, input logic [PLEN-1:0] a, input logic [2:0] acc,
                          input logic pm, input logic exp_m, input int exp_idx,
                          input logic exp_allow, input int exp_lat);
    int lat;
    check({name, ".ready"}, req_ready_o, 1);
    issue(a, acc, pm, lat);
    check({name, ".lat"}, lat, exp_lat);
    check({name, ".matched"}, matched_o, exp_m);
    check({name, ".idx"}, match_idx_o, exp_idx);
    check({name, ".allow"}, allow_o, exp_allow);
    release_rsp(0);
  endtask

  // Reference: each entry is a byte range [lo, hi); the first enabled range containing addr wins.
  function automatic void model(input logic [PLEN-1:0] a, input logic [2:0] acc, input logic pm,
                                output logic m, output int idx, output logic al, output int lat);
    logic [63:0] cur, prev, lo, hi, sz, ad;
    int t;
    m = 1'b0; idx = 0; al = pm; lat = NR + 1;
    ad = 64'(a);
    for (int k = 0; k < NR; k++) begin
      cur  = 64'(cfg_addr[k]) * 4;
      prev = (k == 0) ? 64'd0 : 64'(cfg_addr[k-1]) * 4;
      lo = 0; hi = 0;
      case (cfg[k][4:3])
        2'd1: begin lo = prev; hi = cur; end
        2'd2: begin lo = cur; hi = cur + 4; end
        2'd3: begin
          t = 0;
          while (t < PMP_LEN && cfg_addr[k][t]) t++;
          sz = 64'd1 << (t + 3);
          lo = cur - (cur % sz);
          hi = lo + sz;
        end
        default: ;
      endcase
      if (!m && cfg[k][4:3] != 2'd0 && ad >= lo && ad < hi) begin
        m   = 1'b1;
        idx = k;
        al  = (pm && !cfg[k][7]) || ((acc & ~cfg[k][2:0]) == 3'b000);
        lat = k + 2;
      end
    end
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, n_rsp;
    logic em, ea;
    int ei, el;
    logic [PLEN-1:0] ra;
    logic [2:0] racc;
    logic rpm;
    logic [63:0] v;

    tor_vecs[0] = '{56'h800,  3'b001, 1'b0, 1'b1, 0, 1'b1, 2};
    tor_vecs[1] = '{56'h800,  3'b010, 1'b0, 1'b1, 0, 1'b0, 2};
    tor_vecs[2] = '{56'h0,    3'b000, 1'b0, 1'b1, 0, 1'b1, 2};
    tor_vecs[3] = '{56'hFFF,  3'b111, 1'b0, 1'b1, 0, 1'b0, 2};
    tor_vecs[4] = '{56'h1000, 3'b001, 1'b0, 1'b0, 0, 1'b0, 17};
    tor_vecs[5] = '{56'h1000, 3'b001, 1'b1, 1'b0, 0, 1'b1, 17};
    tor_vecs[6] = '{56'h800,  3'b010, 1'b1, 1'b1, 0, 1'b1, 2};

    rst_i = 1'b1; req_valid_i = 1'b0; addr_i = '0; access_i = '0; priv_m_i = 1'b0;
    flush_i = 1'b0; rsp_ready_i = 1'b0;
    clear_cfg();
    repeat (3) tick();
    rst_i = 1'b0;
    tick();

    check("reset.ready", req_ready_o, 1);
    check("reset.rsp_valid", rsp_valid_o, 0);
    check("reset.allow", allow_o, 0);
    check("reset.matched", matched_o, 0);
    check("reset.idx", match_idx_o, 0);

    // TOR entry 0 covering [0, 0x1000), read only
    cfg_addr[0] = 54'h400; cfg[0] = 8'h09;
    for (int i = 0; i < 7; i++)
      do_check($sformatf("tor%0d", i), tor_vecs[i].addr, tor_vecs[i].acc, tor_vecs[i].pm,
               tor_vecs[i].exp_m, tor_vecs[i].exp_idx, tor_vecs[i].exp_allow, tor_vecs[i].exp_lat);

    // NAPOT priority: entry3 32 B at 0x8000 RWX, entry5 64 B at 0x8000 no perms
    clear_cfg();
    cfg_addr[3] = 54'h2003; cfg[3] = 8'h1F;
    cfg_addr[5] = 54'h2007; cfg[5] = 8'h18;
    do_check("napot_hi", 56'h8010, 3'b100, 1'b0, 1'b1, 3, 1'b1, 5);
    do_check("napot_lo", 56'h8030, 3'b100, 1'b0, 1'b1, 5, 1'b0, 7);
    do_check("napot_miss", 56'h8040, 3'b100, 1'b0, 1'b0, 0, 1'b0, 17);

    clear_cfg();
    do_check("miss_u", 56'h1234, 3'b001, 1'b0, 1'b0, 0, 1'b0, 17);
    do_check("miss_m", 56'h1234, 3'b001, 1'b1, 1'b0, 0, 1'b1, 17);

    // Lock on NA4 at 0x1000
    cfg_addr[0] = 54'h400; cfg[0] = 8'h91;
    do_check("lock_l1", 56'h1000, 3'b010, 1'b1, 1'b1, 0, 1'b0, 2);
    cfg[0] = 8'h11;
    do_check("lock_l0", 56'h1003, 3'b010, 1'b1, 1'b1, 0, 1'b1, 2);
    do_check("na4_edge", 56'h1004, 3'b010, 1'b1, 1'b0, 0, 1'b1, 17);

    // TOR from the previous entry, and an all-ones NAPOT covering everything
    clear_cfg();
    cfg_addr[1] = 54'h400;
    cfg_addr[2] = 54'h800; cfg[2] = 8'h0B;
    cfg_addr[4] = '1;      cfg[4] = 8'h19;
    do_check("tor_below", 56'hFFF,  3'b010, 1'b0, 1'b1, 4, 1'b0, 6);
    do_check("tor_lo",    56'h1000, 3'b010, 1'b0, 1'b1, 2, 1'b1, 4);
    do_check("tor_top",   56'h1FFF, 3'b011, 1'b0, 1'b1, 2, 1'b1, 4);
    do_check("napot_all", {PLEN{1'b1}}, 3'b001, 1'b0, 1'b1, 4, 1'b1, 6);

    // Backpressure: result held while rsp_ready_i stays low, then flush in RESP
    clear_cfg();
    cfg_addr[0] = 54'h400; cfg[0] = 8'h09;
    issue(56'h800, 3'b001, 1'b0, lat);
    check("bp.lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp%0d.valid", i), rsp_valid_o, 1);
      check($sformatf("bp%0d.ready", i), req_ready_o, 0);
      check($sformatf("bp%0d.allow", i), allow_o, 1);
      check($sformatf("bp%0d.matched", i), matched_o, 1);
      check($sformatf("bp%0d.idx", i), match_idx_o, 0);
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_resp.valid", rsp_valid_o, 0);
    check("flush_resp.ready", req_ready_o, 1);
    do_check("after_flush", 56'h800, 3'b010, 1'b0, 1'b1, 0, 1'b0, 2);

    // Flush mid-scan: no response may appear
    clear_cfg();
    addr_i = 56'h40; access_i = 3'b001; priv_m_i = 1'b1; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    repeat (3) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_rsp = 0;
    for (int i = 0; i < 25; i++) begin
      if (rsp_valid_o) n_rsp++;
      tick();
    end
    check("flush_scan.rsp_count", n_rsp, 0);
    check("flush_scan.ready", req_ready_o, 1);

    // Flush in IDLE drops a simultaneous request
    req_valid_i = 1'b1; flush_i = 1'b1;
    tick();
    req_valid_i = 1'b0; flush_i = 1'b0;
    n_rsp = 0;
    for (int i = 0; i < 25; i++) begin
      if (rsp_valid_o || !req_ready_o) n_rsp++;
      tick();
    end
    check("flush_idle.busy_count", n_rsp, 0);

    // Reset mid-scan after a response left allow_o high
    do_check("pre_reset", 56'h40, 3'b001, 1'b1, 1'b0, 0, 1'b1, 17);
    addr_i = 56'h40; access_i = 3'b001; priv_m_i = 1'b1; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    check("rst_scan.ready", req_ready_o, 1);
    check("rst_scan.valid", rsp_valid_o, 0);
    check("rst_scan.allow", allow_o, 0);
    rst_i = 1'b0;
    tick();

    // Random configurations and requests against the reference model
    for (int it = 0; it < 300; it++) begin
      if (it % 10 == 0) begin
        for (int k = 0; k < NR; k++) begin
          case ($urandom_range(0, 3))
            0: v = 64'($urandom_range(0, 'h7FF));
            1: v = (64'($urandom_range(0, 'h3F)) << 6) | ((64'd1 << $urandom_range(0, 5)) - 1);
            2: v = 64'(k * 'h40 + $urandom_range(0, 'h3F));
            default: v = ($urandom_range(0, 15) == 0) ? '1 : 64'($urandom_range(0, 'h3FF));
          endcase
          cfg_addr[k] = PMP_LEN'(v);
          cfg[k]      = 8'($urandom());
        end
      end
      ra   = ($urandom_range(0, 7) == 0) ? PLEN'({$urandom(), $urandom()})
                                         : PLEN'($urandom_range(0, 'h4000));
      racc = 3'($urandom());
      rpm  = 1'($urandom());
      model(ra, racc, rpm, em, ei, ea, el);
      check($sformatf("rnd%0d.ready", it), req_ready_o, 1);
      issue(ra, racc, rpm, lat);
      check($sformatf("rnd%0d.lat", it), lat, el);
      check($sformatf("rnd%0d.matched", it), matched_o, em);
      check($sformatf("rnd%0d.idx", it), match_idx_o, ei);
      check($sformatf("rnd%0d.allow", it), allow_o, ea);
      release_rsp($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
